mux74151_emulator: RTL and testbench

Board-level behavioural emulator of a 74151 8-to-1 multiplexer: the responder end of the pin interface a 74151 chip-checker drives. It receives the checker's stimulus pins and returns Y and W with a programmable settling delay and optional fault injection. On the bench it replaces a physical chip so checker pass/fail paths can be proven without parts.

---
 rtl/mux74151_emulator.sv | 200 ++++++++++++++++++++
 tb/tb_mux74151_emulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux74151_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : mux74151_emulator
//  Purpose  : Pin-level responder emulating a 74151 8-to-1 multiplexer with a
//             programmable settling delay. Optional fault injection is
//             compiled in when CHIP74151_FAULT_INJECT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module mux74151_emulator #(
    parameter int DELAY_CYC = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] D,
    input  logic [2:0] Sel,
    input  logic       G_n,
    input  logic [1:0] Fault,
    output logic       Y,
    output logic       W,
    output logic       Settled,
    output logic [7:0] ChangeCnt
);

    localparam logic [3:0] c_DELAY_LOAD = 4'(DELAY_CYC);
    localparam bit         c_ZERO_DELAY = (DELAY_CYC == 0);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_IDLE   = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [11:0] sync1_q,   sync1_d;
    logic [11:0] sync2_q,   sync2_d;
    logic [11:0] sp_q,      sp_d;
    logic        fill_q,    fill_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [7:0]  chg_q,     chg_d;
    logic        y_q,       y_d;
    logic        w_q,       w_d;
    logic        settled_q, settled_d;

    logic        w_change;
    logic [11:0] w_src;
    logic [7:0]  w_src_data;
    logic [2:0]  w_eff_sel;
    logic        w_y_new;
    logic        w_w_new;

    // Stimulus vector layout: {G_n, Sel[2:0], D[7:0]}
    assign sync1_d  = {G_n, Sel, D};
    assign sync2_d  = sync1_q;
    assign w_change = (sync2_q != sp_q);

    // The only commit taken while still in FILL happens with a zero delay on the
    // fill-exit edge, where the second stage has not yet caught the pins.
    assign w_src      = (state_q == ST_FILL) ? sync1_q : sync2_q;
    assign w_src_data = w_src[7:0];

`ifdef CHIP74151_FAULT_INJECT_EN
    logic [1:0] fsync1_q, fsync1_d;
    logic [1:0] fsync2_q, fsync2_d;
    logic [1:0] fault_r_q, fault_r_d;
    logic [1:0] w_src_fault;
    logic       w_y_pre;

    assign fsync1_d    = Fault;
    assign fsync2_d    = fsync1_q;
    assign w_src_fault = (state_q == ST_FILL) ? fsync1_q : fsync2_q;
    assign w_eff_sel   = {w_src[10:9], w_src[8] & (w_src_fault != 2'b11)};
    assign w_y_pre     = ~w_src[11] & w_src_data[w_eff_sel];
    assign w_y_new     = (w_src_fault == 2'b01) ? 1'b0 : w_y_pre;
    assign w_w_new     = (w_src_fault == 2'b10) ? w_y_new : ~w_y_new;
`else
    logic w_unused_fault;

    assign w_unused_fault = ^Fault;
    assign w_eff_sel      = w_src[10:8];
    assign w_y_new        = ~w_src[11] & w_src_data[w_eff_sel];
    assign w_w_new        = ~w_y_new;
`endif

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        chg_d     = chg_q;
        y_d       = y_q;
        w_d       = w_q;
        settled_d = settled_q;
        // While filling, Sp shadows the value S is about to take so the
        // synchronizer ramp-up is never mistaken for a stimulus change.
        sp_d      = (state_q == ST_FILL) ? sync1_q : sync2_q;
`ifdef CHIP74151_FAULT_INJECT_EN
        fault_r_d = fault_r_q;
`endif

        case (state_q)
            ST_FILL: begin
                fill_d = 1'b1;
                if (fill_q) begin
                    if (c_ZERO_DELAY) begin
                        y_d       = w_y_new;
                        w_d       = w_w_new;
                        settled_d = 1'b1;
`ifdef CHIP74151_FAULT_INJECT_EN
                        fault_r_d = w_src_fault;
`endif
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d   = c_DELAY_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (w_change) begin
                    chg_d = (chg_q == 8'hFF) ? chg_q : chg_q + 8'd1;
                    cnt_d = c_DELAY_LOAD;
                end else if (cnt_q <= 4'd1) begin
                    y_d       = w_y_new;
                    w_d       = w_w_new;
                    settled_d = 1'b1;
`ifdef CHIP74151_FAULT_INJECT_EN
                    fault_r_d = w_src_fault;
`endif
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_IDLE: begin
                if (w_change) begin
                    chg_d = (chg_q == 8'hFF) ? chg_q : chg_q + 8'd1;
                    if (c_ZERO_DELAY) begin
                        y_d       = w_y_new;
                        w_d       = w_w_new;
`ifdef CHIP74151_FAULT_INJECT_EN
                        fault_r_d = w_src_fault;
`endif
                    end else begin
                        settled_d = 1'b0;
                        cnt_d     = c_DELAY_LOAD;
                        state_d   = ST_SETTLE;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_FILL;
            sync1_q   <= 12'd0;
            sync2_q   <= 12'd0;
            sp_q      <= 12'd0;
            fill_q    <= 1'b0;
            cnt_q     <= 4'd0;
            chg_q     <= 8'd0;
            y_q       <= 1'b0;
            w_q       <= 1'b1;
            settled_q <= 1'b0;
`ifdef CHIP74151_FAULT_INJECT_EN
            fsync1_q  <= 2'b00;
            fsync2_q  <= 2'b00;
            fault_r_q <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sp_q      <= sp_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            chg_q     <= chg_d;
            y_q       <= y_d;
            w_q       <= w_d;
            settled_q <= settled_d;
`ifdef CHIP74151_FAULT_INJECT_EN
            fsync1_q  <= fsync1_d;
            fsync2_q  <= fsync2_d;
            fault_r_q <= fault_r_d;
`endif
        end
    end

    assign Y         = y_q;
    assign W         = w_q;
    assign Settled   = settled_q;
    assign ChangeCnt = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_mux74151_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux74151_emulator
//  Purpose  : Self-checking bench for mux74151_emulator at delays 2, 4 and 0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux74151_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic [2:0] sel;
    logic       g_n;
    logic [1:0] fault;

    logic [2:0] o_y, o_w, o_set;
    logic [7:0] o_cnt [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux74151_emulator #(.DELAY_CYC(2)) u_dut_d2 (
        .Clk(clk), .Reset(rst), .D(d), .Sel(sel), .G_n(g_n), .Fault(fault),
        .Y(o_y[0]), .W(o_w[0]), .Settled(o_set[0]), .ChangeCnt(o_cnt[0]));
    mux74151_emulator #(.DELAY_CYC(4)) u_dut_d4 (
        .Clk(clk), .Reset(rst), .D(d), .Sel(sel), .G_n(g_n), .Fault(fault),
        .Y(o_y[1]), .W(o_w[1]), .Settled(o_set[1]), .ChangeCnt(o_cnt[1]));
    mux74151_emulator #(.DELAY_CYC(0)) u_dut_d0 (
        .Clk(clk), .Reset(rst), .D(d), .Sel(sel), .G_n(g_n), .Fault(fault),
        .Y(o_y[2]), .W(o_w[2]), .Settled(o_set[2]), .ChangeCnt(o_cnt[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int dly_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 0);
    endfunction

    // Reference output for a pin snapshot {fault, g_n, sel, d}.
    function automatic logic [1:0] ref_out(input logic [13:0] v);
        logic [7:0] dd;
        int         s;
        logic       yy, ww;
        dd = v[7:0];
        s  = int'(v[10:8]);
`ifdef CHIP74151_FAULT_INJECT_EN
        if (v[13:12] == 2'b11) s = s & 6;
`endif
        yy = v[11] ? 1'b0 : dd[s];
`ifdef CHIP74151_FAULT_INJECT_EN
        if (v[13:12] == 2'b01) yy = 1'b0;
        ww = (v[13:12] == 2'b10) ? yy : ~yy;
`else
        ww = ~yy;
`endif
        return {yy, ww};
    endfunction

    // Model: pin history indexed by edge number since reset release.
    logic [13:0] hist [4096];
    int   k;
    int   m_last [3];
    int   m_cnt  [3];
    logic m_y [3], m_w [3], m_set [3];

    task automatic model_step(input int i);
        int         dl;
        bit         det;
        logic [1:0] o;
        dl  = dly_of(i);
        det = (k >= 4) && (hist[(k - 2) & 4095][11:0] != hist[(k - 3) & 4095][11:0]);
        if (det) begin
            if (m_cnt[i] < 255) m_cnt[i]++;
            m_last[i] = k;
            if (dl > 0) m_set[i] = 1'b0;
        end
        if (k == m_last[i] + dl) begin
            o = ref_out(hist[((k >= 3) ? k - 2 : 1) & 4095]);
            m_y[i]   = o[1];
            m_w[i]   = o[0];
            m_set[i] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            k = 0;
            for (int i = 0; i < 3; i++) begin
                m_last[i] = 2; m_cnt[i] = 0;
                m_y[i] = 1'b0; m_w[i] = 1'b1; m_set[i] = 1'b0;
            end
        end else begin
            k = k + 1;
            hist[k & 4095] = {fault, g_n, sel, d};
            for (int i = 0; i < 3; i++) model_step(i);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_y_dly%0d k=%0d", dly_of(i), k), 32'(o_y[i]), 32'(m_y[i]));
            chk($sformatf("model_w_dly%0d k=%0d", dly_of(i), k), 32'(o_w[i]), 32'(m_w[i]));
            chk($sformatf("model_settled_dly%0d k=%0d", dly_of(i), k), 32'(o_set[i]), 32'(m_set[i]));
            chk($sformatf("model_cnt_dly%0d k=%0d", dly_of(i), k), 32'(o_cnt[i]), 32'(m_cnt[i]));
        end
    end

    typedef struct {
        logic [7:0] d;
        logic [2:0] sel;
        logic       g_n;
        logic [1:0] fault;
        logic       ey;
        logic       ew;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base4;
        int r;
        int b;

        tbl[0] = '{8'hA5, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[1] = '{8'hA5, 3'd1, 1'b0, 2'b00, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, 3'd7, 1'b1, 2'b00, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 3'd7, 1'b0, 2'b00, 1'b1, 1'b0};
`ifdef CHIP74151_FAULT_INJECT_EN
        tbl[4] = '{8'hFF, 3'd2, 1'b0, 2'b01, 1'b0, 1'b1};
        tbl[5] = '{8'h01, 3'd1, 1'b0, 2'b11, 1'b1, 1'b0};
        tbl[6] = '{8'h03, 3'd1, 1'b0, 2'b10, 1'b1, 1'b1};
        tbl[9] = '{8'h7F, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0};
`else
        tbl[4] = '{8'hFF, 3'd2, 1'b0, 2'b01, 1'b1, 1'b0};
        tbl[5] = '{8'h01, 3'd1, 1'b0, 2'b11, 1'b0, 1'b1};
        tbl[6] = '{8'h03, 3'd1, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[9] = '{8'h7F, 3'd6, 1'b1, 2'b10, 1'b0, 1'b1};
`endif
        tbl[7] = '{8'h80, 3'd7, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[8] = '{8'h7F, 3'd7, 1'b0, 2'b00, 1'b0, 1'b1};

        // Reset and first commit
        rst = 1'b1; d = 8'hA5; sel = 3'd0; g_n = 1'b0; fault = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_y", 32'(o_y[0]), 32'd0);
        chk("reset_w", 32'(o_w[0]), 32'd1);
        chk("reset_settled", 32'(o_set[0]), 32'd0);
        chk("reset_cnt", 32'(o_cnt[0]), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("first_commit_not_early", 32'(o_set[0]), 32'd0);
        @(posedge clk);
        #2;
        chk("first_commit_y", 32'(o_y[0]), 32'd1);
        chk("first_commit_w", 32'(o_w[0]), 32'd0);
        chk("first_commit_settled", 32'(o_set[0]), 32'd1);
        chk("first_commit_cnt", 32'(o_cnt[0]), 32'd0);

        // Select change latency
        @(negedge clk); sel = 3'd1;
        @(posedge clk);
        @(posedge clk); #2 chk("sel_e1_settled", 32'(o_set[0]), 32'd1);
        @(posedge clk); #2 chk("sel_e2_settled", 32'(o_set[0]), 32'd0);
        chk("sel_e2_cnt", 32'(o_cnt[0]), 32'd1);
        @(posedge clk); #2 chk("sel_e3_y_held", 32'(o_y[0]), 32'd1);
        @(posedge clk); #2 chk("sel_e4_y", 32'(o_y[0]), 32'd0);
        chk("sel_e4_w", 32'(o_w[0]), 32'd1);
        chk("sel_e4_settled", 32'(o_set[0]), 32'd1);

        // Repeated changes keep restarting the settle (delay 4)
        @(negedge clk); sel = 3'd3;
        repeat (10) @(negedge clk);
        base4 = int'(o_cnt[1]);
        for (int i = 0; i < 5; i++) begin
            d[3] = ~d[3];
            @(negedge clk);
            @(negedge clk);
        end
        chk("toggle_settled_low", 32'(o_set[1]), 32'd0);
        @(posedge clk); #2;
        chk("toggle_cnt", 32'(o_cnt[1]), 32'(base4 + 5));
        chk("toggle_y_held", 32'(o_y[1]), 32'd0);
        repeat (3) @(posedge clk);
        #2 chk("toggle_e5_y_held", 32'(o_y[1]), 32'd0);
        @(posedge clk); #2;
        chk("toggle_e6_y", 32'(o_y[1]), 32'd1);
        chk("toggle_e6_w", 32'(o_w[1]), 32'd0);
        chk("toggle_e6_settled", 32'(o_set[1]), 32'd1);

        // Function table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d = tbl[i].d; sel = tbl[i].sel; g_n = tbl[i].g_n; fault = tbl[i].fault;
            repeat (8) @(negedge clk);
            chk($sformatf("table_y_row%0d", i), 32'(o_y[0]), 32'(tbl[i].ey));
            chk($sformatf("table_w_row%0d", i), 32'(o_w[0]), 32'(tbl[i].ew));
            chk($sformatf("table_settled_row%0d", i), 32'(o_set[0]), 32'd1);
        end

        // Random stimulus against the model
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                d = 8'($urandom); sel = 3'($urandom_range(0, 7));
                g_n = 1'($urandom_range(0, 1)); fault = 2'($urandom_range(0, 3));
            end else if (r == 2) begin
                sel = 3'($urandom_range(0, 7));
            end else if (r == 3) begin
                b = int'($urandom_range(0, 7));
                d[b] = ~d[b];
            end else if (r == 4) begin
                fault = 2'($urandom_range(0, 3));
            end
        end

        // Reset in the middle of a settle
        repeat (12) @(negedge clk);
        sel = sel ^ 3'd1;
        repeat (3) @(posedge clk);
        #2 chk("midsettle_settled_low", 32'(o_set[1]), 32'd0);
        @(negedge clk); rst = 1'b1;
        #2;
        chk("midsettle_rst_y", 32'(o_y[1]), 32'd0);
        chk("midsettle_rst_w", 32'(o_w[1]), 32'd1);
        chk("midsettle_rst_settled", 32'(o_set[1]), 32'd0);
        chk("midsettle_rst_cnt", 32'(o_cnt[1]), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Saturation of the change counter
        repeat (8) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            d[0] = ~d[0];
            @(negedge clk);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("sat_cnt_d2", 32'(o_cnt[0]), 32'd255);
        chk("sat_cnt_d4", 32'(o_cnt[1]), 32'd255);
        chk("sat_cnt_d0", 32'(o_cnt[2]), 32'd255);

        repeat (8) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
